// File: rtl/rf_pkg.sv
// Shared types for the register-file write arbiter slice.
package rf_pkg;

   localparam int RF_DW = 8;
   localparam int RF_PW = 4;

   typedef logic [RF_PW-1:0] rf_addr_t;
   typedef logic [RF_DW-1:0] rf_data_t;

   typedef struct packed {
      logic     valid;
      rf_addr_t addr;
      rf_data_t data;
   } rf_wreq_t;

endpackage

// File: rtl/rf_wr_arbiter_rr.sv
// rr_arbiter: N-way round-robin arbiter.
// The grant is combinational. The priority pointer moves past the winner on advance.
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win;
   logic             found;

   // Scan from ptr, wrapping modulo N; the first requester seen wins.
   always_comb begin
      int j;
      j     = 0;
      grant = '0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && req[j]) begin
            found    = 1'b1;
            win      = PTR_W'(j);
            grant[j] = 1'b1;
         end
      end
   end

   // The winner gets lowest priority next. The pointer holds when nobody was granted.
   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (advance && found)
         ptr <= (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
   end

endmodule

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares one register-file write port among NREQ writeback sources.
// It also tracks registers whose writes are still in flight, so decode can stall on them.
// Optional macro RF_WR_FWD_EN adds a same-cycle forwarding path from the write register.
module rf_wr_arbiter
   import rf_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int PW   = RF_PW,
   parameter int DW   = RF_DW
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0][PW-1:0]  req_addr,
   input  logic [NREQ-1:0][DW-1:0]  req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     wr_en,
   output logic [PW-1:0]            wr_addr,
   output logic [DW-1:0]            dat_in,
   input  logic                     rsv_valid,
   input  logic [PW-1:0]            rsv_addr,
   output logic                     rsv_conflict,
   input  logic [PW-1:0]            qry_addr,
   output logic                     qry_pending,
   input  logic [PW-1:0]            fwd_addr,
   output logic                     fwd_hit,
   output logic [DW-1:0]            fwd_data
);

   typedef struct packed {
      logic          valid;
      logic [PW-1:0] addr;
      logic [DW-1:0] data;
   } wreq_t;

   logic [NREQ-1:0]    grant;
   logic [PW-1:0]      sel_addr;
   logic [DW-1:0]      sel_data;
   wreq_t              wq;
   logic [2**PW-1:0]   busy;

   // While reset is high, requests are masked, so nothing is granted and the pointer cannot move.
   rr_arbiter #(.N(NREQ)) u_rr (
      .clk     (clk),
      .reset   (reset),
      .req     (req_valid & {NREQ{~reset}}),
      .advance (~reset),
      .grant   (grant)
   );

   assign req_ready = grant;

   // Mux the granted requester's address and data. The grant is one-hot, so OR-ing is exact.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr = sel_addr | req_addr[i];
            sel_data = sel_data | req_data[i];
         end
      end
   end

   // Write-port register: a grant in this cycle becomes the commit in the next cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         wq <= '0;
      end else begin
         wq.valid <= |grant;
         if (|grant) begin
            wq.addr <= sel_addr;
            wq.data <= sel_data;
         end
      end
   end

   assign wr_en   = wq.valid;
   assign wr_addr = wq.addr;
   assign dat_in  = wq.data;

   // Scoreboard. A commit clears the register's bit and a reservation sets it.
   // The set is applied last, so a same-register reservation stays outstanding.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy         <= '0;
         rsv_conflict <= 1'b0;
      end else begin
         rsv_conflict <= rsv_valid & busy[rsv_addr] & ~(wq.valid & (wq.addr == rsv_addr));
         if (wq.valid)
            busy[wq.addr] <= 1'b0;
         if (rsv_valid)
            busy[rsv_addr] <= 1'b1;
      end
   end

   assign qry_pending = busy[qry_addr];

`ifdef RF_WR_FWD_EN
   assign fwd_hit  = wq.valid & (wq.addr == fwd_addr);
   assign fwd_data = wq.data;
`else
   logic unused_fwd;
   assign unused_fwd = ^fwd_addr;
   assign fwd_hit    = 1'b0;
   assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter.
// A behavioural model is compared against the DUT on every checked cycle.
// Directed steps add hand-computed literal expectations.
module tb_rf_wr_arbiter;

   localparam int NREQ = 3;
   localparam int PW   = 4;
   localparam int DW   = 8;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [NREQ-1:0]         req_valid;
   logic [NREQ-1:0][PW-1:0] req_addr;
   logic [NREQ-1:0][DW-1:0] req_data;
   logic [NREQ-1:0]         req_ready;
   logic                    wr_en;
   logic [PW-1:0]           wr_addr;
   logic [DW-1:0]           dat_in;
   logic                    rsv_valid;
   logic [PW-1:0]           rsv_addr;
   logic                    rsv_conflict;
   logic [PW-1:0]           qry_addr;
   logic                    qry_pending;
   logic [PW-1:0]           fwd_addr;
   logic                    fwd_hit;
   logic [DW-1:0]           fwd_data;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   rf_wr_arbiter #(.NREQ(NREQ), .PW(PW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_conflict(rsv_conflict),
      .qry_addr(qry_addr), .qry_pending(qry_pending),
      .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
   );

   // ---------------- behavioural model ----------------
   int m_ptr  = 0;
   bit m_busy [16];
   bit m_wen  = 0;
   int m_waddr = 0;
   int m_wdat  = 0;
   bit m_conf = 0;

   // Returns the index of the current winner, or -1 when nothing is granted.
   function automatic int pick();
      int i;
      if (reset) return -1;
      for (int k = 0; k < NREQ; k++) begin
         i = (m_ptr + k) % NREQ;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int g;
      g = pick();
      if (reset) begin
         m_ptr = 0; m_wen = 0; m_waddr = 0; m_wdat = 0; m_conf = 0;
         for (int r = 0; r < 16; r++) m_busy[r] = 0;
      end else begin
         m_conf = rsv_valid && m_busy[rsv_addr] && !(m_wen && m_waddr == int'(rsv_addr));
         if (m_wen) m_busy[m_waddr] = 0;
         if (rsv_valid) m_busy[rsv_addr] = 1;
         if (g >= 0) begin
            m_wen = 1; m_waddr = int'(req_addr[g]); m_wdat = int'(req_data[g]);
            m_ptr = (g + 1) % NREQ;
         end else begin
            m_wen = 0;
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Compare the DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      int g;
      logic [31:0] exp_rdy, exp_hit, exp_fd;
      if (chk_en) begin
         g = pick();
         exp_rdy = (g < 0) ? 32'd0 : (32'd1 << g);
`ifdef RF_WR_FWD_EN
         exp_hit = (m_wen && m_waddr == int'(fwd_addr)) ? 32'd1 : 32'd0;
         exp_fd  = 32'(m_wdat);
`else
         exp_hit = 32'd0;
         exp_fd  = 32'd0;
`endif
         check("m_req_ready", 32'(req_ready), exp_rdy);
         check("m_wr_en", 32'(wr_en), 32'(m_wen));
         check("m_wr_addr", 32'(wr_addr), 32'(m_waddr));
         check("m_dat_in", 32'(dat_in), 32'(m_wdat));
         check("m_rsv_conflict", 32'(rsv_conflict), 32'(m_conf));
         check("m_qry_pending", 32'(qry_pending), 32'(m_busy[qry_addr]));
         check("m_fwd_hit", 32'(fwd_hit), exp_hit);
         check("m_fwd_data", 32'(fwd_data), exp_fd);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; req_valid = 3'b111;
      req_addr[0] = 4'd1; req_addr[1] = 4'd2; req_addr[2] = 4'd3;
      req_data[0] = 8'h11; req_data[1] = 8'h22; req_data[2] = 8'h33;
      rsv_valid = 1'b0; rsv_addr = '0; qry_addr = '0; fwd_addr = '0;

      // Reset with all requesters valid
      step(); step();
      @(negedge clk);
      chk_en = 1'b1;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_wr_en", 32'(wr_en), 32'd0);
      check("rst_pending", 32'(qry_pending), 32'd0);

      // All three valid: grants 0,1,2,0 with writes lagging by one cycle
      step(); reset = 1'b0;
      @(negedge clk); check("rr_first", 32'(req_ready), 32'b001);
      step(); @(negedge clk);
      check("rr_wen", 32'(wr_en), 32'd1); check("rr_a1", 32'(wr_addr), 32'd1);
      check("rr_g1", 32'(req_ready), 32'b010);
      step(); @(negedge clk);
      check("rr_a2", 32'(wr_addr), 32'd2); check("rr_g2", 32'(req_ready), 32'b100);
      step(); @(negedge clk);
      check("rr_a3", 32'(wr_addr), 32'd3); check("rr_g0", 32'(req_ready), 32'b001);
      step(); @(negedge clk);
      check("rr_a1b", 32'(wr_addr), 32'd1);

      // Only requester 2 valid, with wrap of the pointer back to 0
      step(); req_valid = 3'b100; req_addr[2] = 4'd5; req_data[2] = 8'hA5; fwd_addr = 4'd5;
      @(negedge clk); check("solo_ready", 32'(req_ready), 32'b100);
      step(); req_valid = 3'b011;
      @(negedge clk);
      check("solo_wen", 32'(wr_en), 32'd1); check("solo_addr", 32'(wr_addr), 32'd5);
      check("solo_data", 32'(dat_in), 32'hA5); check("wrap_ptr0", 32'(req_ready), 32'b001);
`ifdef RF_WR_FWD_EN
      check("fwd_hit", 32'(fwd_hit), 32'd1); check("fwd_data", 32'(fwd_data), 32'hA5);
`else
      check("fwd_off", 32'(fwd_hit), 32'd0);
`endif

      // Reserve r7, then write r7 to clear it; a second reservation while busy conflicts
      step(); req_valid = 3'b000; rsv_valid = 1'b1; rsv_addr = 4'd7; qry_addr = 4'd7;
      @(negedge clk); check("rsv_pre", 32'(qry_pending), 32'd0);
      step(); rsv_valid = 1'b0; req_valid = 3'b010; req_addr[1] = 4'd7; req_data[1] = 8'h77;
      @(negedge clk);
      check("rsv_set", 32'(qry_pending), 32'd1); check("r7_grant", 32'(req_ready), 32'b010);
      step(); req_valid = 3'b000;
      @(negedge clk);
      check("r7_wen", 32'(wr_en), 32'd1); check("r7_addr", 32'(wr_addr), 32'd7);
      check("r7_still", 32'(qry_pending), 32'd1);
      step(); @(negedge clk); check("r7_clear", 32'(qry_pending), 32'd0);
      step(); rsv_valid = 1'b1; rsv_addr = 4'd7;
      @(negedge clk); check("conf_none", 32'(rsv_conflict), 32'd0);
      step(); @(negedge clk);
      check("conf_none2", 32'(rsv_conflict), 32'd0); check("r7_busy", 32'(qry_pending), 32'd1);
      step(); rsv_valid = 1'b0;
      @(negedge clk); check("conf_pulse", 32'(rsv_conflict), 32'd1);
      step(); @(negedge clk); check("conf_end", 32'(rsv_conflict), 32'd0);

      // Commit to r4 in the same cycle as a new reservation of r4: the set wins
      step(); rsv_valid = 1'b1; rsv_addr = 4'd4; qry_addr = 4'd4;
      step(); rsv_valid = 1'b0; req_valid = 3'b001; req_addr[0] = 4'd4; req_data[0] = 8'h44;
      @(negedge clk); check("r4_grant", 32'(req_ready), 32'b001);
      step(); req_valid = 3'b000; rsv_valid = 1'b1; rsv_addr = 4'd4;
      @(negedge clk); check("r4_wen", 32'(wr_en), 32'd1); check("r4_addr", 32'(wr_addr), 32'd4);
      step(); rsv_valid = 1'b0;
      @(negedge clk);
      check("r4_setwins", 32'(qry_pending), 32'd1); check("r4_noconf", 32'(rsv_conflict), 32'd0);

      // Reset in requester 1's grant cycle drops the grant
      step(); req_valid = 3'b010; req_addr[1] = 4'd9; req_data[1] = 8'h99; reset = 1'b1;
      @(negedge clk); check("mid_rst_ready", 32'(req_ready), 32'd0);
      step(); reset = 1'b0; req_valid = 3'b000;
      @(negedge clk);
      check("mid_rst_wen", 32'(wr_en), 32'd0); check("mid_rst_busy", 32'(qry_pending), 32'd0);

      // Mixed traffic, checked against the model
      for (int n = 0; n < 400; n++) begin
         step();
         req_valid = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            req_addr[i] = PW'($urandom);
            req_data[i] = DW'($urandom);
         end
         rsv_valid = ($urandom_range(0, 2) == 0);
         rsv_addr  = PW'($urandom_range(0, 5));
         qry_addr  = PW'($urandom_range(0, 5));
         fwd_addr  = PW'($urandom);
         reset     = ($urandom_range(0, 60) == 0);
      end
      step(); reset = 1'b0; req_valid = '0; rsv_valid = 1'b0;
      @(negedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
